// File: rtl/yuv_bram_pkg.sv
// yuv_bram_pkg
// Shared definitions for the YUV line-buffer BRAM controller.
//   DEPTH_DEF  : default number of words per bank (one video line)
//   rd_state_t : read-side FSM state encoding
package yuv_bram_pkg;

  localparam int DEPTH_DEF = 96;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_READ = 2'd1,
    R_DONE = 2'd2
  } rd_state_t;

endpackage

// File: rtl/addr_wrap_cnt.sv
// addr_wrap_cnt
// Address counter that advances on enable and wraps to zero after DEPTH-1.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears the count
//   en    : advance the count this cycle
//   count : current address (AW bits)
//   wrap  : high in the cycle where an enabled advance wraps DEPTH-1 -> 0
module addr_wrap_cnt #(
  parameter int DEPTH = 96,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [AW-1:0] count,
  output logic          wrap
);

  // The wrap pulse is combinational so the owner can update flags/banks
  // on the same edge that returns the count to zero.
  assign wrap = en && (count == AW'(DEPTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      if (wrap) begin
        count <= '0;
      end else begin
        count <= count + AW'(1);
      end
    end
  end

endmodule

// File: rtl/yuv_bram_ctrl.sv
// yuv_bram_ctrl
// Ping-pong (two bank) BRAM controller for buffering YUV video lines.
// A producer fills one bank while a consumer reads out the other.
// Ports:
//   clk, rst_n         : clock (rising edge), async active-low reset
//   data_valid         : producer offers a word this cycle
//   w_ready            : current write bank is not full
//   wr_en/wr_bank/wr_addr : BRAM write port controls
//   rd_start           : consumer requests readout of the next full bank
//   rd_en/rd_bank/rd_addr : BRAM read port controls
//   rd_valid           : BRAM read data valid (rd_en delayed one cycle)
//   rd_done            : one-cycle pulse after the last read address
//   bank_full          : per-bank full flags
//   drop_cnt           : saturating count of words offered while not ready
module yuv_bram_ctrl
  import yuv_bram_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          data_valid,
  output logic          w_ready,
  output logic          wr_en,
  output logic          wr_bank,
  output logic [AW-1:0] wr_addr,
  input  logic          rd_start,
  output logic          rd_en,
  output logic          rd_bank,
  output logic [AW-1:0] rd_addr,
  output logic          rd_valid,
  output logic          rd_done,
  output logic [1:0]    bank_full,
  output logic [7:0]    drop_cnt
);

  rd_state_t state, state_nxt;
  logic      wr_wrap;
  logic      rd_wrap;

  // Write side: ready depends only on registered flags, so no combinational
  // path exists from data_valid back to w_ready.
  assign w_ready = ~bank_full[wr_bank];
  assign wr_en   = data_valid & w_ready;

  addr_wrap_cnt #(.DEPTH(DEPTH), .AW(AW)) u_wr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (wr_en),
    .count (wr_addr),
    .wrap  (wr_wrap)
  );

  addr_wrap_cnt #(.DEPTH(DEPTH), .AW(AW)) u_rd_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (rd_en),
    .count (rd_addr),
    .wrap  (rd_wrap)
  );

  // Write bank flips on the same edge the last word of a line is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank <= 1'b0;
    end else if (wr_wrap) begin
      wr_bank <= ~wr_bank;
    end
  end

  // Set and clear always target different banks (the writer can only fill
  // a bank the reader is not draining), so both updates can apply together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_full <= 2'b00;
    end else begin
      if (wr_wrap) begin
        bank_full[wr_bank] <= 1'b1;
      end
      if (state == R_DONE) begin
        bank_full[rd_bank] <= 1'b0;
      end
    end
  end

  // Saturating drop counter for words offered while the write bank is full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= 8'd0;
    end else if (data_valid && !w_ready && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // Read FSM state register, plus the read-bank toggle and read-data-valid
  // pipeline stage that follow it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= R_IDLE;
      rd_bank  <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      rd_valid <= rd_en;
      if (state == R_DONE) begin
        rd_bank <= ~rd_bank;
      end
    end
  end

  // Read FSM next-state logic; a request for an empty bank is dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      R_IDLE: if (rd_start && bank_full[rd_bank]) state_nxt = R_READ;
      R_READ: if (rd_wrap) state_nxt = R_DONE;
      R_DONE: state_nxt = R_IDLE;
      default: state_nxt = R_IDLE;
    endcase
  end

  // Read FSM outputs are decoded from state alone.
  always_comb begin
    rd_en   = 1'b0;
    rd_done = 1'b0;
    case (state)
      R_READ:  rd_en   = 1'b1;
      R_DONE:  rd_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_yuv_bram_ctrl.sv
// tb_yuv_bram_ctrl
// Scoreboard bench for yuv_bram_ctrl: stimulus pushes expected write/read
// {bank,addr} pairs, a negedge monitor pops and compares them whenever the
// DUT strobes wr_en or rd_en. Status outputs are checked directly.
module tb_yuv_bram_ctrl;

  localparam int DEPTH = 96;
  localparam int AW    = 7;

  logic          clk;
  logic          rst_n;
  logic          data_valid;
  logic          w_ready;
  logic          wr_en;
  logic          wr_bank;
  logic [AW-1:0] wr_addr;
  logic          rd_start;
  logic          rd_en;
  logic          rd_bank;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic          rd_done;
  logic [1:0]    bank_full;
  logic [7:0]    drop_cnt;

  int num_checks = 0;
  int num_fails  = 0;

  logic [7:0] wr_exp_q[$];
  logic [7:0] rd_exp_q[$];
  logic       prev_rd_en = 1'b0;

  yuv_bram_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_valid (data_valid),
    .w_ready    (w_ready),
    .wr_en      (wr_en),
    .wr_bank    (wr_bank),
    .wr_addr    (wr_addr),
    .rd_start   (rd_start),
    .rd_en      (rd_en),
    .rd_bank    (rd_bank),
    .rd_addr    (rd_addr),
    .rd_valid   (rd_valid),
    .rd_done    (rd_done),
    .bank_full  (bank_full),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input int act, input int exp);
    num_checks++;
    if (act != exp) begin
      num_fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rd_done(output int n);
    n = 0;
    while (!rd_done && n < 300) begin
      tick();
      n++;
    end
  endtask

  // Monitor: compares every BRAM strobe against the scoreboard queues.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst_n) begin
      prev_rd_en = 1'b0;
    end else begin
      if (wr_en) begin
        if (wr_exp_q.size() == 0) begin
          check_output("unexpected_write", {24'd0, wr_bank, wr_addr}, -1);
        end else begin
          e = wr_exp_q.pop_front();
          check_output("write_bank_addr", {24'd0, wr_bank, wr_addr}, {24'd0, e});
        end
      end
      if (rd_en) begin
        if (rd_exp_q.size() == 0) begin
          check_output("unexpected_read", {24'd0, rd_bank, rd_addr}, -1);
        end else begin
          e = rd_exp_q.pop_front();
          check_output("read_bank_addr", {24'd0, rd_bank, rd_addr}, {24'd0, e});
        end
      end
      if (rd_en || rd_valid || prev_rd_en) begin
        check_output("rd_valid_lag", int'(rd_valid), int'(prev_rd_en));
      end
      prev_rd_en = rd_en;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    rst_n      = 1'b0;
    data_valid = 1'b0;
    rd_start   = 1'b0;
    repeat (3) tick();

    // Reset values
    check_output("reset_w_ready",   int'(w_ready), 1);
    check_output("reset_bank_full", int'(bank_full), 0);
    check_output("reset_drop_cnt",  int'(drop_cnt), 0);
    check_output("reset_rd_en",     int'(rd_en), 0);
    check_output("reset_rd_done",   int'(rd_done), 0);
    rst_n = 1'b1;
    tick();

    // rd_start with no full bank is ignored
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    check_output("empty_rd_start_rd_en", int'(rd_en), 0);
    repeat (3) tick();
    check_output("empty_rd_start_full", int'(bank_full), 0);

    // One full line into bank 0
    for (int i = 0; i < DEPTH; i++) begin
      wr_exp_q.push_back({1'b0, 7'(i)});
      data_valid = 1'b1;
      tick();
    end
    data_valid = 1'b0;
    check_output("line0_bank_full", int'(bank_full), 1);
    check_output("line0_wr_bank",   int'(wr_bank), 1);
    check_output("line0_w_ready",   int'(w_ready), 1);
    check_output("line0_wr_addr",   int'(wr_addr), 0);

    // Read out bank 0
    for (int i = 0; i < DEPTH; i++) rd_exp_q.push_back({1'b0, 7'(i)});
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    check_output("rd_first_latency", int'(rd_en), 1);
    check_output("rd_first_addr",    int'(rd_addr), 0);
    wait_rd_done(n);
    check_output("rd_done_latency",  n, DEPTH);
    check_output("rd_done_rd_valid", int'(rd_valid), 1);
    tick();
    check_output("rd0_bank_full", int'(bank_full), 0);
    check_output("rd0_rd_bank",   int'(rd_bank), 1);
    check_output("rd0_done_pulse", int'(rd_done), 0);

    // Fill bank 1, start reading it, reset at read address 50
    for (int i = 0; i < DEPTH; i++) begin
      wr_exp_q.push_back({1'b1, 7'(i)});
      data_valid = 1'b1;
      tick();
    end
    data_valid = 1'b0;
    check_output("line1_bank_full", int'(bank_full), 2);
    for (int i = 0; i < 50; i++) rd_exp_q.push_back({1'b1, 7'(i)});
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    n = 0;
    while (rd_addr != 7'd50 && n < 200) begin
      tick();
      n++;
    end
    check_output("reach_rd_addr50", n, 50);
    #1;
    rst_n = 1'b0;
    #1;
    check_output("midrst_rd_en",     int'(rd_en), 0);
    check_output("midrst_rd_valid",  int'(rd_valid), 0);
    check_output("midrst_rd_addr",   int'(rd_addr), 0);
    check_output("midrst_rd_bank",   int'(rd_bank), 0);
    check_output("midrst_wr_bank",   int'(wr_bank), 0);
    check_output("midrst_bank_full", int'(bank_full), 0);
    check_output("midrst_w_ready",   int'(w_ready), 1);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Fill both banks, then overflow by 10 words
    for (int i = 0; i < 2 * DEPTH; i++) begin
      wr_exp_q.push_back({(i >= DEPTH) ? 1'b1 : 1'b0, 7'(i % DEPTH)});
      data_valid = 1'b1;
      tick();
    end
    check_output("both_bank_full", int'(bank_full), 3);
    check_output("both_w_ready",   int'(w_ready), 0);
    check_output("both_wr_en",     int'(wr_en), 0);
    repeat (10) tick();
    check_output("drop_cnt_10", int'(drop_cnt), 10);

    // Read bank 0 with data_valid still high; writes resume after rd_done
    for (int i = 0; i < DEPTH; i++) rd_exp_q.push_back({1'b0, 7'(i)});
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    wait_rd_done(n);
    check_output("rd_done_latency2", n, DEPTH);
    check_output("rd_done_w_ready",  int'(w_ready), 0);
    check_output("drop_cnt_107",     int'(drop_cnt), 107);
    for (int i = 0; i < 4; i++) wr_exp_q.push_back({1'b0, 7'(i)});
    tick();
    check_output("resume_w_ready",   int'(w_ready), 1);
    check_output("resume_wr_en",     int'(wr_en), 1);
    check_output("resume_wr_addr",   int'(wr_addr), 0);
    check_output("resume_wr_bank",   int'(wr_bank), 0);
    check_output("resume_bank_full", int'(bank_full), 2);
    check_output("drop_cnt_108",     int'(drop_cnt), 108);
    repeat (4) tick();
    data_valid = 1'b0;
    check_output("resume_wr_addr4", int'(wr_addr), 4);

    repeat (3) tick();
    check_output("wr_queue_drained", wr_exp_q.size(), 0);
    check_output("rd_queue_drained", rd_exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_fails);
    $finish;
  end

endmodule

// File: doc/yuv_bram_ctrl.md
YUV_BRAM_CTRL -- requirements
Module: yuv_bram_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 96, meaning entries per bank (words per line).
REQ-002 SHALL have parameter AW, default 7, meaning address width; DEPTH <= 2**AW.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port data_valid  input  1  producer has a word this cycle.
REQ-006 SHALL have port w_ready  output  1  controller can accept a write this cycle.
REQ-007 SHALL have port wr_en  output  1  BRAM write strobe.
REQ-008 SHALL have port wr_bank  output  1  bank being written (0/1).
REQ-009 SHALL have port wr_addr  output  AW  BRAM write address within wr_bank.
REQ-010 SHALL have port rd_start  input  1  consumer requests readout of the next full bank.
REQ-011 SHALL have port rd_en  output  1  BRAM read strobe.
REQ-012 SHALL have port rd_bank  output  1  bank being read.
REQ-013 SHALL have port rd_addr  output  AW  BRAM read address within rd_bank.
REQ-014 SHALL have port rd_valid  output  1  BRAM read data valid (rd_en delayed 1 cycle).
REQ-015 SHALL have port rd_done  output  1  one-cycle pulse: bank readout finished.
REQ-016 SHALL have port bank_full  output  2  per-bank full flags.
REQ-017 SHALL have port drop_cnt  output  8  saturating count of rejected words.

Function
REQ-018 SHALL drive w_ready = ~bank_full[wr_bank], decoded from registers only.
REQ-019 SHALL drive wr_en = data_valid & w_ready combinationally, with wr_addr = current write count.
REQ-020 SHALL increment the write count on each accepted word; at count DEPTH-1 accepted: count -> 0, bank_full[wr_bank] set, wr_bank toggles, all at the same edge.
REQ-021 SHALL hold write count and wr_bank when data_valid=0 or w_ready=0.
REQ-022 SHALL increment drop_cnt on data_valid & ~w_ready, saturating at 255.
REQ-023 SHALL implement read FSM states R_IDLE, R_READ, R_DONE.
REQ-024 R_IDLE -> R_READ when rd_start & bank_full[rd_bank]; rd_start otherwise ignored.
REQ-025 In R_READ SHALL assert rd_en every cycle, rd_addr 0,1,...,DEPTH-1, then -> R_DONE after addr DEPTH-1.
REQ-026 In R_DONE SHALL pulse rd_done one cycle, clear bank_full[rd_bank], toggle rd_bank, -> R_IDLE.
REQ-027 SHALL ignore rd_start outside R_IDLE; latency rd_start to first rd_en = 1 cycle.
REQ-028 Full-set (write side) and full-clear (read side) on the same edge SHALL both take effect (different banks by construction).
REQ-029 With both banks full, w_ready SHALL stay 0 until the R_DONE edge clears the read bank; writing resumes the following cycle.

Reset
REQ-030 On rst_n low SHALL asynchronously force: counts 0, wr_bank 0, rd_bank 0, bank_full 00, drop_cnt 0, FSM R_IDLE, rd_en/rd_valid/rd_done 0; w_ready thus 1 after reset.
REQ-031 Reset mid-transfer SHALL discard partial line and any full flags; no pending state survives.

Structure
REQ-032 SHALL place DEPTH default and FSM state encoding in shared package yuv_bram_pkg.
REQ-033 SHALL use one sub-module addr_wrap_cnt (enable, wrap at DEPTH-1, wrap pulse), instantiated for write and read counts.

Verification
REQ-034 96 consecutive valid words from reset -> wr_addr 0..95 on bank 0, bank_full=01, wr_bank=1 next cycle.
REQ-035 192 valid words, no rd_start -> bank_full=11, w_ready=0; 10 more valid -> drop_cnt=10.
REQ-036 Bank 0 full, rd_start pulse -> rd_en 96 cycles addr 0..95 bank 0, rd_valid lagging 1 cycle, rd_done pulse, bank_full[0] cleared.
REQ-037 Both full, rd_start, valid held high -> w_ready rises cycle after rd_done, writes resume at bank 0 addr 0.
REQ-038 rd_start with bank_full=00 -> no rd_en; rst_n low at read addr 50 -> all outputs at reset values immediately.
